bus_arbiter_mux: RTL and testbench

Parametrised, registered bus source multiplexer for the processor datapath; it is the successor to the fixed 10-input, 16-bit combinational bus mux. It selects one of NUM_IN WIDTH-bit sources onto the shared bus in one of two modes:
- direct select, driven by the control unit;
- round-robin arbitration among requesting sources.

The output is registered, with valid, grant and select-error flags, so bus timing is decoupled from control decode.

---
 rtl/bus_mux_pkg.sv | 18 +
 rtl/bus_arbiter_mux_rr.sv | 54 +++++
 rtl/bus_arbiter_mux.sv | 98 +++++++++
 tb/tb_bus_arbiter_mux.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bus_mux_pkg.sv
// Shared types and constants for the bus source multiplexer.
// Mode encodings, default sizes and the flattened-source offset helper.
package bus_mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NUM_IN = 10;

  function automatic int slice_off(
    input int idx,
    input int width
  );
    return idx * width;
  endfunction

endpackage

// File: rtl/bus_arbiter_mux_rr.sv
// Round-robin arbiter: owns the rotating priority pointer.
// Winner is the first request at or after ptr, wrapping at NUM_IN.
module rr_arbiter #(
  parameter int NUM_IN = 10,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              advance_i,
  input  logic [NUM_IN-1:0] req_i,
  output logic [IDX_W-1:0]  winner_o,
  output logic              any_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] win;
  logic             found;
  int               pos;

  // Scan requests starting at the pointer, first hit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NUM_IN) pos = pos - NUM_IN;
      if (!found && req_i[pos]) begin
        found = 1'b1;
        win   = pos[IDX_W-1:0];
      end
    end
  end

  assign winner_o = win;
  assign any_o    = found;

  // Next pointer sits just past the winner, wrapping to zero.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      if (win == IDX_W'(NUM_IN - 1)) ptr_d = '0;
      else ptr_d = win + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered bus source mux: direct select or round-robin.
// Outputs update one cycle after the sampled inputs.
module bus_arbiter_mux
  import bus_mux_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    CLOCK_50,
  input  logic                    Resetn,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_en,
  input  logic [NUM_IN-1:0]       req,
  input  logic [NUM_IN*WIDTH-1:0] din,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_valid,
  output logic [NUM_IN-1:0]       grant,
  output logic                    sel_err
);

  localparam int IDX_W = $clog2(NUM_IN);

  logic [WIDTH-1:0]  src [NUM_IN];
  logic [IDX_W-1:0]  winner;
  logic              any_req;
  logic              advance;
  logic              sel_ok;

  logic [WIDTH-1:0]  bus_q, bus_d;
  logic              valid_q, valid_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic              err_q, err_d;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_src
    assign src[i] = din[slice_off(i, WIDTH) +: WIDTH];
  end

  assign advance = (mode == MODE_RR);
  assign sel_ok  = {{(32-SEL_W){1'b0}}, sel} < 32'(NUM_IN);

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr (
    .clk_i     (CLOCK_50),
    .rst_ni    (Resetn),
    .advance_i (advance),
    .req_i     (req),
    .winner_o  (winner),
    .any_o     (any_req)
  );

  // Mode decode and source select; bus holds unless a legal load.
  always_comb begin
    bus_d   = bus_q;
    valid_d = 1'b0;
    grant_d = '0;
    err_d   = 1'b0;
    if (mode == MODE_RR) begin
      if (any_req) begin
        bus_d   = src[winner];
        valid_d = 1'b1;
        grant_d = NUM_IN'(1) << winner;
      end
    end else if (sel_en) begin
      if (sel_ok) begin
        bus_d   = src[sel];
        valid_d = 1'b1;
        grant_d = NUM_IN'(1) << sel;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      bus_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  assign bus_out   = bus_q;
  assign bus_valid = valid_q;
  assign grant     = grant_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux at default parameters.
// Source i carries 3*i+1.
module tb_bus_arbiter_mux;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic [3:0]    sel;
  logic          sel_en;
  logic [9:0]    req;
  logic [159:0]  din;
  logic [15:0]   bus_out;
  logic          bus_valid;
  logic [9:0]    grant;
  logic          sel_err;

  int errors = 0;
  int checks = 0;

  bus_arbiter_mux dut (
    .CLOCK_50  (clk),
    .Resetn    (rst_n),
    .mode      (mode),
    .sel       (sel),
    .sel_en    (sel_en),
    .req       (req),
    .din       (din),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .grant     (grant),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [15:0] e_bus,
                         input logic        e_valid,
                         input logic [9:0]  e_grant,
                         input logic        e_err);
    chk({tag, ".bus"},   32'(bus_out),   32'(e_bus));
    chk({tag, ".valid"}, 32'(bus_valid), 32'(e_valid));
    chk({tag, ".grant"}, 32'(grant),     32'(e_grant));
    chk({tag, ".err"},   32'(sel_err),   32'(e_err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    mode   = 1'b0;
    sel    = 4'd0;
    sel_en = 1'b0;
    req    = 10'h000;
    for (int i = 0; i < 10; i++) din[i*16 +: 16] = 16'(3*i + 1);

    repeat (3) step();
    chk_all("reset_held", 16'd0, 1'b0, 10'h000, 1'b0);
    #2 rst_n = 1'b1;
    step();
    chk_all("after_release", 16'd0, 1'b0, 10'h000, 1'b0);

    // direct sweep
    sel_en = 1'b1;
    for (int s = 0; s < 10; s++) begin
      sel = 4'(s);
      step();
      chk_all($sformatf("direct%0d", s), 16'(3*s + 1), 1'b1,
              10'(1 << s), 1'b0);
    end

    // illegal selects
    sel = 4'd10;
    step();
    chk_all("illegal10", 16'd28, 1'b0, 10'h000, 1'b1);
    sel = 4'd15;
    step();
    chk_all("illegal15", 16'd28, 1'b0, 10'h000, 1'b1);
    sel = 4'd2;
    step();
    chk_all("legal2", 16'd7, 1'b1, 10'h004, 1'b0);
    sel_en = 1'b0;
    step();
    chk_all("no_strobe", 16'd7, 1'b0, 10'h000, 1'b0);

    // round robin, all requesting; sel is illegal and must be ignored
    mode   = 1'b1;
    sel    = 4'd15;
    sel_en = 1'b1;
    req    = 10'h3FF;
    for (int n = 0; n < 13; n++) begin
      step();
      chk_all($sformatf("rr_all%0d", n), 16'(3*(n % 10) + 1), 1'b1,
              10'(1 << (n % 10)), 1'b0);
    end

    // sparse with wrap; ptr is now 3
    req = 10'b1000000100;
    step();
    chk_all("sparse_a", 16'd28, 1'b1, 10'h200, 1'b0);
    step();
    chk_all("sparse_b", 16'd7, 1'b1, 10'h004, 1'b0);
    step();
    chk_all("sparse_c", 16'd28, 1'b1, 10'h200, 1'b0);
    req = 10'h000;
    step();
    chk_all("rr_idle", 16'd28, 1'b0, 10'h000, 1'b0);

    // mode switch; ptr is now 0
    req = 10'h010;
    step();
    chk_all("rr_grant4", 16'd13, 1'b1, 10'h010, 1'b0);
    mode = 1'b0;
    sel  = 4'd7;
    req  = 10'h3FF;
    step();
    chk_all("switch_direct", 16'd22, 1'b1, 10'h080, 1'b0);
    mode = 1'b1;
    step();
    chk_all("switch_back", 16'd16, 1'b1, 10'h020, 1'b0);

    // async reset mid-stream, no clock edge in between
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_reset", 16'd0, 1'b0, 10'h000, 1'b0);
    #2 rst_n = 1'b1;
    step();
    chk_all("post_reset_ptr", 16'd1, 1'b1, 10'h001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
